// File: rtl/wave_channel_gen.sv
// Wave-table playback channel: steps through a writable sample table at a programmable rate,
// with an optional length countdown and a 4-level output attenuator.
module wave_channel_gen #(
  parameter int unsigned SAMPLE_W = 4,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned FREQ_W   = 11,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk256,
  input  logic                     dac_en,
  input  logic                     trigger,
  input  logic [FREQ_W-1:0]        freq,
  input  logic [LEN_W-1:0]         len_load,
  input  logic                     len_enable,
  input  logic [1:0]               vol_code,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [SAMPLE_W-1:0]      wr_data,
  output logic [SAMPLE_W-1:0]      sample_out,
  output logic                     active
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [FREQ_W:0] FREQ_SPAN = {1'b1, {FREQ_W{1'b0}}};
  localparam logic [LEN_W:0]  LEN_SPAN  = {1'b1, {LEN_W{1'b0}}};

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       pos_q, pos_d;
  logic [FREQ_W:0]     timer_q, timer_d;
  logic [LEN_W:0]      len_q, len_d;
  logic                active_q, active_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [FREQ_W:0]     reload_val;
  logic [LEN_W:0]      len_init;
  logic [SAMPLE_W-1:0] cur_sample;

  assign reload_val = FREQ_SPAN - {1'b0, freq};
  assign len_init   = LEN_SPAN - {1'b0, len_load};
  // Read sees the pre-write table contents, so a same-cycle write shows up one cycle later.
  assign cur_sample = mem_q[pos_q];

  always_comb begin
    pos_d    = pos_q;
    timer_d  = timer_q;
    len_d    = len_q;
    active_d = active_q;
    if (!dac_en) begin
      active_d = 1'b0;
    end else if (trigger) begin
      active_d = 1'b1;
      pos_d    = '0;
      timer_d  = reload_val;
      len_d    = len_init;
    end else if (active_q) begin
      if (timer_q == (FREQ_W+1)'(1)) begin
        pos_d   = pos_q + 1'b1;
        timer_d = reload_val;
      end else begin
        timer_d = timer_q - 1'b1;
      end
      if (clk256 && len_enable && (len_q != '0)) begin
        len_d = len_q - 1'b1;
        if (len_q == (LEN_W+1)'(1)) active_d = 1'b0;
      end
    end
  end

  always_comb begin
    sample_d = '0;
    if (active_q) begin
      case (vol_code)
        2'd0:    sample_d = '0;
        2'd1:    sample_d = cur_sample;
        2'd2:    sample_d = cur_sample >> 1;
        default: sample_d = cur_sample >> 2;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= '0;
      timer_q  <= '0;
      len_q    <= '0;
      active_q <= 1'b0;
      sample_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      pos_q    <= pos_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      active_q <= active_d;
      sample_q <= sample_d;
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

  assign sample_out = sample_q;
  assign active     = active_q;

endmodule

// File: tb/tb_wave_channel_gen.sv
// Bench for wave_channel_gen: scripted corner sequences, a volume vector table and a random
// run, all checked against a cycle-level behavioural model of the channel.
module tb_wave_channel_gen;
  localparam int DP = 32;
  localparam int FW = 11;
  localparam int LW = 8;

  logic clk = 1'b0, rst_n = 1'b0, clk256 = 1'b0, dac_en = 1'b0, trigger = 1'b0;
  logic len_enable = 1'b0, wr_en = 1'b0, wr_en2 = 1'b0;
  logic [FW-1:0] freq = '0;
  logic [LW-1:0] len_load = '0;
  logic [1:0]    vol_code = '0;
  logic [4:0]    wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic [5:0]    wr_addr2 = '0;
  logic [7:0]    wr_data2 = '0;
  logic [3:0]    sample_out;
  logic [7:0]    sample_out2;
  logic          active, active2;

  always #5 clk = ~clk;

  wave_channel_gen dut (
    .clk(clk), .rst_n(rst_n), .clk256(clk256), .dac_en(dac_en), .trigger(trigger),
    .freq(freq), .len_load(len_load), .len_enable(len_enable), .vol_code(vol_code),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sample_out(sample_out), .active(active)
  );

  wave_channel_gen #(.SAMPLE_W(8), .DEPTH(64), .FREQ_W(11), .LEN_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .clk256(clk256), .dac_en(dac_en), .trigger(trigger),
    .freq(freq), .len_load(len_load), .len_enable(len_enable), .vol_code(vol_code),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .sample_out(sample_out2), .active(active2)
  );

  // Model: elapsed cycles since the last step vs. the period latched at trigger/step.
  int m_active, m_pos, m_elapsed, m_period, m_len, m_out;
  int m_tab [DP];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] fill;
    logic [1:0] vol;
    int         exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_pos = 0; m_elapsed = 0; m_period = 0; m_len = 0; m_out = 0;
    for (int i = 0; i < DP; i++) m_tab[i] = 0;
  endfunction

  function automatic void model_edge();
    int s, o;
    s = m_tab[m_pos];
    o = 0;
    if (m_active != 0) begin
      case (vol_code)
        2'd0: o = 0;
        2'd1: o = s;
        2'd2: o = s / 2;
        default: o = s / 4;
      endcase
    end
    if (!dac_en) begin
      m_active = 0;
    end else if (trigger) begin
      m_active = 1; m_pos = 0; m_elapsed = 0;
      m_period = 2048 - int'(freq);
      m_len = 256 - int'(len_load);
    end else if (m_active != 0) begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_pos = (m_pos + 1) % DP;
        m_elapsed = 0;
        m_period = 2048 - int'(freq);
      end
      if (clk256 && len_enable && m_len > 0) begin
        m_len--;
        if (m_len == 0) m_active = 0;
      end
    end
    if (wr_en) m_tab[wr_addr] = int'(wr_data);
    m_out = o;
  endfunction

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
    check("model_out", int'(sample_out), m_out);
    check("model_active", int'(active), m_active);
  endtask

  initial begin
    vecs[0] = '{4'hC, 2'd1, 12};
    vecs[1] = '{4'hC, 2'd2, 6};
    vecs[2] = '{4'hC, 2'd3, 3};
    vecs[3] = '{4'hC, 2'd0, 0};
    vecs[4] = '{4'hF, 2'd2, 7};
    vecs[5] = '{4'hF, 2'd3, 3};
    vecs[6] = '{4'h9, 2'd2, 4};
    vecs[7] = '{4'h1, 2'd3, 0};

    model_reset();
    dac_en = 1'b1;
    #2;
    check("rst_out", int'(sample_out), 0);
    check("rst_active", int'(active), 0);
    check("rst_out64", int'(sample_out2), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp table, two-cycle step period.
    for (int i = 0; i < DP; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 4'((i < 16) ? i : 31 - i);
      tick();
    end
    wr_en = 1'b0;
    freq = 11'd2046; vol_code = 2'd1; len_enable = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      int idx;
      tick();
      idx = ((k - 1) / 2) % DP;
      check("ramp_seq", int'(sample_out), (idx < 16) ? idx : 31 - idx);
    end

    // Length expiry after two strobes, then no expiry with len_enable=0.
    len_load = 8'd254; len_enable = 1'b1;
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (3) tick();
    clk256 = 1'b1; tick(); clk256 = 1'b0;
    check("len_first_strobe", int'(active), 1);
    repeat (2) tick();
    clk256 = 1'b1; tick(); clk256 = 1'b0;
    check("len_second_strobe", int'(active), 0);
    tick();
    check("len_out_zero", int'(sample_out), 0);
    len_enable = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (3) begin
      clk256 = 1'b1; tick(); clk256 = 1'b0; tick();
    end
    check("len_disabled_active", int'(active), 1);

    // Trigger and strobe together: load wins, next strobe expires.
    len_load = 8'd255; len_enable = 1'b1;
    trigger = 1'b1; clk256 = 1'b1; tick(); trigger = 1'b0; clk256 = 1'b0;
    check("trig_prio_active", int'(active), 1);
    repeat (2) tick();
    clk256 = 1'b1; tick(); clk256 = 1'b0;
    check("trig_prio_expire", int'(active), 0);

    // Volume vectors over a uniformly filled table.
    len_enable = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < DP; i++) begin
        wr_en = 1'b1; wr_addr = 5'(i); wr_data = vecs[v].fill;
        tick();
      end
      wr_en = 1'b0;
      vol_code = vecs[v].vol;
      repeat (2) tick();
      check("vol_vec", int'(sample_out), vecs[v].exp);
    end

    // Write to the current position while playing; dac_en gating.
    freq = 11'd0; vol_code = 2'd1;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 4'd3; tick(); wr_en = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick();
    check("wr_before", int'(sample_out), 3);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 4'd7; tick(); wr_en = 1'b0;
    check("wr_same_cycle_old", int'(sample_out), 3);
    tick();
    check("wr_next_cycle_new", int'(sample_out), 7);
    dac_en = 1'b0; tick();
    check("dac_off_active", int'(active), 0);
    trigger = 1'b1; tick(); trigger = 1'b0;
    check("trig_dac_off_active", int'(active), 0);
    tick();
    check("dac_off_out", int'(sample_out), 0);
    dac_en = 1'b1;

    // Asynchronous reset in the middle of playback.
    freq = 11'd2046;
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out", int'(sample_out), 0);
    check("mid_rst_active", int'(active), 0);
    trigger = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 4'd5; clk256 = 1'b1;
    tick();
    trigger = 1'b0; wr_en = 1'b0; clk256 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", int'(active), 0);
    trigger = 1'b1; tick(); trigger = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_rst_table_zero", int'(sample_out), 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      dac_en     = ($urandom % 20) != 0;
      trigger    = ($urandom % 30) == 0;
      clk256     = ($urandom % 5) == 0;
      len_enable = ($urandom % 4) != 0;
      len_load   = (($urandom % 3) == 0) ? 8'($urandom) : 8'($urandom_range(250, 255));
      freq       = (($urandom % 8) == 0) ? 11'($urandom) : 11'(2048 - $urandom_range(1, 4));
      vol_code   = 2'($urandom);
      wr_en      = ($urandom % 3) == 0;
      wr_addr    = 5'($urandom);
      wr_data    = 4'($urandom);
      tick();
    end
    trigger = 1'b0; clk256 = 1'b0; wr_en = 1'b0; dac_en = 1'b1;

    // 64-entry build wraps 63 -> 0.
    for (int i = 0; i < 64; i++) begin
      wr_en2 = 1'b1; wr_addr2 = 6'(i); wr_data2 = 8'(i);
      tick();
    end
    wr_en2 = 1'b0;
    freq = 11'd2047; len_enable = 1'b0; vol_code = 2'd1;
    trigger = 1'b1; tick(); trigger = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      check("wrap64_seq", int'(sample_out2), (k - 1) % 64);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
